// File: rtl/rf_wb_if.sv
// Writeback bus for rf_wb_queue: two producer request channels (ALU, load) and the
// register-file write port.
interface rf_wb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            rf_we;
  logic [AW-1:0]   rf_ad;
  logic [XLEN-1:0] rf_wd;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, rf_we, rf_ad, rf_wd
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, rf_we, rf_ad, rf_wd
  );
endinterface

// File: rtl/rf_wb_queue.sv
// Two-producer in-order writeback FIFO driving the register-file write port, with a
// pending-write scoreboard. Define RF_WB_BYPASS_EN to forward the youngest queued data.
module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rf_wb_if.slave                 wb,
  input  logic [AW-1:0]          rs1,
  input  logic [AW-1:0]          rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic                   rs1_fwd_valid,
  output logic                   rs2_fwd_valid,
  output logic [XLEN-1:0]        rs1_fwd_data,
  output logic [XLEN-1:0]        rs2_fwd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]    rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  logic             not_full_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic [AW-1:0]    enq_rd_s;
  logic [XLEN-1:0]  enq_data_s;
  logic [DEPTH-1:0] hit1_s;
  logic [DEPTH-1:0] hit2_s;

  // Physical slot of the entry that is 'age' places behind the head.
  function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] head, input int age);
    return head + PW'(age);
  endfunction

  assign not_full_s   = (count_r < DEPTH_C);
  assign wb.mem_ready = not_full_s;
  assign wb.alu_ready = not_full_s && !wb.mem_valid;
  assign pop_s        = (count_r != {CW{1'b0}});
  assign push_s       = accept_s && (enq_rd_s != {AW{1'b0}});

  // Arbitration: load path has fixed priority; x0 targets handshake but are dropped.
  always_comb begin
    accept_s   = 1'b0;
    enq_rd_s   = wb.alu_rd;
    enq_data_s = wb.alu_data;
    if (wb.mem_valid && not_full_s) begin
      accept_s   = 1'b1;
      enq_rd_s   = wb.mem_rd;
      enq_data_s = wb.mem_data;
    end else if (wb.alu_valid && not_full_s) begin
      accept_s   = 1'b1;
    end else begin
      accept_s   = 1'b0;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      if (push_s && !pop_s)      count_r <= count_r + CW'(1'b1);
      else if (!push_s && pop_s) count_r <= count_r - CW'(1'b1);
    end
  end

  // Entry storage; contents are only observed while occupied, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      rd_q[wr_ptr_r]   <= enq_rd_s;
      data_q[wr_ptr_r] <= enq_data_s;
    end
  end

  assign wb.rf_we = pop_s;
  assign wb.rf_ad = pop_s ? rd_q[rd_ptr_r]   : {AW{1'b0}};
  assign wb.rf_wd = pop_s ? data_q[rd_ptr_r] : {XLEN{1'b0}};
  assign count    = count_r;

  // Per-age match vectors (bit 0 = head) over the occupied entries.
  always_comb begin
    hit1_s = {DEPTH{1'b0}};
    hit2_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_r) begin
        hit1_s[k] = (rd_q[slot_of(rd_ptr_r, k)] == rs1) && (rs1 != {AW{1'b0}});
        hit2_s[k] = (rd_q[slot_of(rd_ptr_r, k)] == rs2) && (rs2 != {AW{1'b0}});
      end else begin
        hit1_s[k] = 1'b0;
        hit2_s[k] = 1'b0;
      end
    end
  end

  assign rs1_busy = |hit1_s;
  assign rs2_busy = |hit2_s;

`ifdef RF_WB_BYPASS_EN
  assign rs1_fwd_valid = rs1_busy;
  assign rs2_fwd_valid = rs2_busy;

  // Scan oldest to youngest so the youngest matching entry is the one left standing.
  always_comb begin
    rs1_fwd_data = {XLEN{1'b0}};
    rs2_fwd_data = {XLEN{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      if (hit1_s[k]) rs1_fwd_data = data_q[slot_of(rd_ptr_r, k)];
      else           rs1_fwd_data = rs1_fwd_data;
      if (hit2_s[k]) rs2_fwd_data = data_q[slot_of(rd_ptr_r, k)];
      else           rs2_fwd_data = rs2_fwd_data;
    end
  end
`else
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = {XLEN{1'b0}};
  assign rs2_fwd_data  = {XLEN{1'b0}};
`endif

endmodule
